// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: a 2-flop input synchronizer feeds a mid-bit sampling FSM.
// Completed bytes land in a valid/ready holding register.
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 1085,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  sysclk,
   input  logic                  rst_n,
   input  logic                  i_enable,
   input  logic                  i_rx_serial,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_frame_err,
   output logic                  o_overrun,
   output logic                  o_busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                  state, state_n;
   logic [CNT_W-1:0]        clk_cnt, clk_cnt_n;
   logic [IDX_W-1:0]        bit_idx, bit_idx_n;
   logic [DATA_WIDTH-1:0]   shift_reg;
   logic                    rx_p0, rx_p1;
   logic                    rx_s;
   logic                    sample_bit;
   logic                    frame_done;
   logic                    frame_bad;

   // Stage p0/p1: synchronizer, preset to idle-high so reset never looks like a start bit
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= i_rx_serial;
         rx_p1 <= rx_p0;
      end
   end

   assign rx_s = rx_p1;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_idx <= '0;
      end else begin
         state   <= state_n;
         clk_cnt <= clk_cnt_n;
         bit_idx <= bit_idx_n;
      end
   end

   always_comb begin
      state_n    = state;
      clk_cnt_n  = clk_cnt + CNT_W'(1);
      bit_idx_n  = bit_idx;
      sample_bit = 1'b0;
      frame_done = 1'b0;
      frame_bad  = 1'b0;
      case (state)
         IDLE: begin
            clk_cnt_n = '0;
            if (i_enable && !rx_s) begin
               state_n = START;
            end
         end
         START: begin
            if (clk_cnt == HALF_CNT) begin
               clk_cnt_n = '0;
               bit_idx_n = '0;
               // A line that is high again at mid-start was a glitch
               state_n   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (clk_cnt == LAST_CNT) begin
               clk_cnt_n  = '0;
               sample_bit = 1'b1;
               if (bit_idx == LAST_IDX) begin
                  state_n = STOP;
               end else begin
                  bit_idx_n = bit_idx + IDX_W'(1);
               end
            end
         end
         STOP: begin
            if (clk_cnt == LAST_CNT) begin
               clk_cnt_n  = '0;
               state_n    = IDLE;
               frame_done = rx_s;
               frame_bad  = !rx_s;
            end
         end
         default: begin
            clk_cnt_n = '0;
            state_n   = IDLE;
         end
      endcase
   end

   // Data-only shift register; its contents matter only once a frame completes
   always_ff @(posedge sysclk) begin
      if (sample_bit) begin
         shift_reg[bit_idx] <= rx_s;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= frame_bad;
         o_overrun   <= frame_done && o_valid && !i_ready;
         if (frame_done) begin
            // A read on the completion edge frees the slot for the new byte
            if (!o_valid || i_ready) begin
               o_data  <= shift_reg;
               o_valid <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with CLKS_PER_BIT = 16 and 8 data bits.
module tb_uart_rx_core;

   localparam int CPB = 16;
   localparam int DW  = 8;

   logic          sysclk = 1'b0;
   logic          rst_n;
   logic          i_enable;
   logic          i_rx_serial;
   logic [DW-1:0] o_data;
   logic          o_valid;
   logic          i_ready;
   logic          o_frame_err;
   logic          o_overrun;
   logic          o_busy;

   int n_assert = 0;
   int n_fail   = 0;

   int n_ferr = 0;
   int n_ovr  = 0;
   int n_both = 0;
   int n_busy = 0;
   int n_vhi  = 0;
   logic [DW-1:0] acc_q[$];

   uart_rx_core #(
      .CLKS_PER_BIT(CPB),
      .DATA_WIDTH  (DW)
   ) dut (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .i_enable   (i_enable),
      .i_rx_serial(i_rx_serial),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_frame_err(o_frame_err),
      .o_overrun  (o_overrun),
      .o_busy     (o_busy)
   );

   always #5 sysclk = ~sysclk;

   // Event monitor, sampled 1 time unit after each falling edge
   always begin
      @(negedge sysclk);
      #1;
      if (o_frame_err) n_ferr++;
      if (o_overrun) n_ovr++;
      if (o_frame_err && o_overrun) n_both++;
      if (o_busy) n_busy++;
      if (o_valid) n_vhi++;
      if (o_valid && i_ready) acc_q.push_back(o_data);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit);
      logic [DW+1:0] bits;
      bits = {stop_bit, d, 1'b0};
      for (int i = 0; i < DW + 2; i++) begin
         i_rx_serial = bits[i];
         repeat (CPB) @(negedge sysclk);
      end
      i_rx_serial = 1'b1;
   endtask

   task automatic read_pulse();
      i_ready = 1'b1;
      @(negedge sysclk);
      i_ready = 1'b0;
   endtask

   int lat;
   int b_ferr, b_ovr, b_busy, b_vhi, b_acc;

   initial begin
      rst_n       = 1'b0;
      i_enable    = 1'b1;
      i_rx_serial = 1'b1;
      i_ready     = 1'b0;
      idle(4);

      check("rst_o_data", 32'(o_data), 32'h00);
      check("rst_o_valid", 32'(o_valid), 32'h0);
      check("rst_o_frame_err", 32'(o_frame_err), 32'h0);
      check("rst_o_overrun", 32'(o_overrun), 32'h0);
      check("rst_o_busy", 32'(o_busy), 32'h0);
      rst_n = 1'b1;
      idle(4);

      // 1: single byte, latency, then a one-cycle read
      lat = -1;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            for (int k = 0; k < 400; k++) begin
               @(posedge sysclk);
               #1;
               if (o_valid) begin
                  lat = k;
                  break;
               end
            end
         end
      join
      n_assert++;
      assert (lat >= 153 && lat <= 155) else begin
         n_fail++;
         $error("FAIL t1_latency: observed %0d cycles expected 154 +/-1", lat);
      end
      check("t1_o_data", 32'(o_data), 32'hA5);
      check("t1_o_valid", 32'(o_valid), 32'h1);
      read_pulse();
      check("t1_valid_cleared", 32'(o_valid), 32'h0);
      check("t1_data_held", 32'(o_data), 32'hA5);
      idle(8);

      // 2: start-bit glitch
      b_ferr = n_ferr; b_ovr = n_ovr; b_busy = n_busy;
      i_rx_serial = 1'b0;
      idle(5);
      i_rx_serial = 1'b1;
      idle(30);
      check("t2_busy_seen", 32'(n_busy > b_busy), 32'h1);
      check("t2_back_idle", 32'(o_busy), 32'h0);
      check("t2_o_valid", 32'(o_valid), 32'h0);
      check("t2_no_ferr", 32'(n_ferr - b_ferr), 32'h0);
      check("t2_no_ovr", 32'(n_ovr - b_ovr), 32'h0);

      // 3: framing error, then a good frame
      b_ferr = n_ferr;
      send_frame(8'h3C, 1'b0);
      idle(24);
      check("t3_one_ferr", 32'(n_ferr - b_ferr), 32'h1);
      check("t3_o_valid", 32'(o_valid), 32'h0);
      send_frame(8'h0B, 1'b1);
      idle(4);
      check("t3_o_data", 32'(o_data), 32'h0B);
      check("t3_o_valid_good", 32'(o_valid), 32'h1);
      read_pulse();
      check("t3_valid_cleared", 32'(o_valid), 32'h0);
      idle(4);

      // 4: overrun with i_ready low
      b_ovr = n_ovr;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      idle(4);
      check("t4_o_data_kept", 32'(o_data), 32'h11);
      check("t4_o_valid", 32'(o_valid), 32'h1);
      check("t4_one_ovr", 32'(n_ovr - b_ovr), 32'h1);
      read_pulse();
      check("t4_valid_cleared", 32'(o_valid), 32'h0);
      idle(4);

      // 5: streaming with i_ready held high
      b_ovr = n_ovr; b_vhi = n_vhi; b_acc = acc_q.size();
      i_ready = 1'b1;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      idle(4);
      i_ready = 1'b0;
      check("t5_accept_count", 32'(acc_q.size() - b_acc), 32'd3);
      if (acc_q.size() >= b_acc + 3) begin
         check("t5_byte0", 32'(acc_q[b_acc]), 32'h00);
         check("t5_byte1", 32'(acc_q[b_acc + 1]), 32'hFF);
         check("t5_byte2", 32'(acc_q[b_acc + 2]), 32'h55);
      end
      check("t5_valid_cycles", 32'(n_vhi - b_vhi), 32'd3);
      check("t5_no_ovr", 32'(n_ovr - b_ovr), 32'h0);
      check("t5_o_valid", 32'(o_valid), 32'h0);
      idle(4);

      // 6: reset during bit 4 of 0xF0, then 0x81
      i_rx_serial = 1'b0;
      idle(5 * CPB);
      i_rx_serial = 1'b1;
      idle(CPB / 2);
      check("t6_busy_mid_frame", 32'(o_busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", 32'(o_busy), 32'h0);
      idle(3);
      rst_n = 1'b1;
      idle(4 * CPB);
      check("t6_no_partial", 32'(o_valid), 32'h0);
      check("t6_rst_data", 32'(o_data), 32'h00);
      send_frame(8'h81, 1'b1);
      idle(4);
      check("t6_o_data", 32'(o_data), 32'h81);
      check("t6_o_valid", 32'(o_valid), 32'h1);
      read_pulse();
      idle(4);

      // 6b: receiver disabled
      b_busy = n_busy;
      i_enable = 1'b0;
      send_frame(8'h5A, 1'b1);
      idle(8);
      check("t6_dis_busy", 32'(n_busy - b_busy), 32'h0);
      check("t6_dis_valid", 32'(o_valid), 32'h0);
      i_enable = 1'b1;
      idle(4);

      check("never_ferr_and_ovr", 32'(n_both), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial-to-parallel UART receiver: 8N1 frame, LSB first, idle-high line. It recovers bytes from the board UART RX pin and presents them on a valid/ready holding register. It sits under uart_top beside the transmitter and feeds the receiver-side logic and the LED6 status indicator. The receiver side of uart_top instantiates it with the shared baud constants.

Parameters:
CLKS_PER_BIT, 1085, sysclk cycles per bit (125 MHz / 115200 baud); legal range 4 or more; benches use 16.
DATA_WIDTH, 8, data bits per frame.

Ports:
sysclk  input  1  system clock, 125 MHz; all state is rising-edge.
rst_n  input  1  asynchronous active-low reset.
i_enable  input  1  receiver enable (BTN3 mode). When low, the FSM is held in IDLE and no frames are accepted.
i_rx_serial  input  1  asynchronous serial line; idle is 1.
o_data  output  DATA_WIDTH  received byte, LSB = first data bit on the line.
o_valid  output  1  o_data holds an unread byte.
i_ready  input  1  consumer accepts o_data when o_valid and i_ready are both 1 on the same edge.
o_frame_err  output  1  one-cycle pulse: the stop bit sampled 0.
o_overrun  output  1  one-cycle pulse: a byte completed while the holding register was full and not being read.
o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE and all counters clear.
  - o_data = 0, o_valid = 0, o_frame_err = 0, o_overrun = 0, o_busy = 0.
  - Synchronizer flops reset to 1, so reset never produces a false start.
- Input synchronizer: i_rx_serial passes through 2 flops to give rx_s. All FSM decisions use rx_s only.
- Bit counter clk_cnt: width is ceil(log2(CLKS_PER_BIT)). It clears on every state change. Bit index bit_idx: width is ceil(log2(DATA_WIDTH)).
- IDLE:
  - If i_enable = 1 and rx_s = 0, go to START and set clk_cnt = 0.
- START:
  - clk_cnt increments each cycle.
  - When clk_cnt = (CLKS_PER_BIT-1)/2 (integer division), test rx_s.
  - If rx_s = 0, go to DATA with bit_idx = 0.
  - If rx_s = 1 (glitch), return to IDLE silently with no flags.
- DATA:
  - When clk_cnt = CLKS_PER_BIT-1, shift rx_s into shift register position bit_idx.
  - If bit_idx = DATA_WIDTH-1, go to STOP; otherwise increment bit_idx and stay in DATA.
- STOP:
  - When clk_cnt = CLKS_PER_BIT-1, sample rx_s and go to IDLE on that same edge.
  - If rx_s = 1, the frame completes (see holding register below).
  - If rx_s = 0, pulse o_frame_err, discard the byte, and leave o_valid unchanged.
  - Because the FSM leaves STOP at mid-stop-bit, a start bit immediately after the stop bit is caught.
- Holding register, evaluated on the completion edge:
  - If o_valid = 0, load o_data and set o_valid = 1.
  - If o_valid = 1 and i_ready = 1 on the same edge, load the new byte and keep o_valid = 1. No overrun.
  - If o_valid = 1 and i_ready = 0, keep the old o_data and o_valid = 1, drop the new byte, and pulse o_overrun.
- Read: o_valid = 1 and i_ready = 1 with no simultaneous completion clears o_valid on the next edge. o_data holds its last value.
- Latency: o_valid rises exactly 2 + (CLKS_PER_BIT-1)/2 + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 cycles after the first sysclk edge on which i_rx_serial is sampled 0. Benches allow ±1 cycle for asynchronous input phase.
- i_enable falling mid-frame: the frame in progress completes normally; i_enable is checked only in IDLE.
- Reset mid-frame: immediate return to IDLE; a partial byte is never delivered.
- o_frame_err and o_overrun never assert in the same cycle.

Test Plan:
1. CLKS_PER_BIT = 16, i_ready = 0, send 0xA5 (line order: 0, 1,0,1,0,0,1,0,1, 1) -> o_valid rises at 2+7+144+1 = 154 ±1 cycles and o_data = 0xA5. Then pulse i_ready for 1 cycle -> o_valid = 0 on the next edge.
2. Glitch: line low for 5 cycles, then high -> FSM returns to IDLE after START, and o_valid, o_frame_err and o_overrun all stay 0.
3. Framing error: send 0x3C with stop bit 0 -> one o_frame_err pulse and o_valid stays 0. Then send 0x0B correctly -> o_data = 0x0B.
4. Overrun: i_ready = 0, send 0x11 then 0x22 back-to-back -> o_data = 0x11, o_valid = 1, and one o_overrun pulse at the second completion.
5. i_ready = 1 throughout, send 0x00, 0xFF, 0x55 back-to-back -> three 1-cycle o_valid pulses with matching data and no overrun.
6. Assert rst_n = 0 during bit 4 of 0xF0, release, then send 0x81 -> only 0x81 is delivered. Also hold i_enable = 0 and send a frame -> o_busy stays 0 and o_valid stays 0.
